// File: rtl/mips_core_pkg.sv
// ---------------------------------------------------------------------------
// mips_core_pkg
//
// Purpose:
//   Shared core-level definitions for the common data bus (CDB). These are the
//   default sizes of a CDB broadcast, the number of units that compete for the
//   bus, and the fixed request-slot assignment of each execution unit.
//
// Contents:
//   CDB_N_REQ, CDB_*_WIDTH  default arbiter sizing
//   CDB_REQ_*               request-slot index of each completing unit
//   cdb_packet_t            one broadcast payload {data, preg, rob}
// ---------------------------------------------------------------------------
package mips_core_pkg;

    // Default CDB sizing.
    localparam int CDB_N_REQ      = 4;
    localparam int CDB_DATA_WIDTH = 32;
    localparam int CDB_PREG_WIDTH = 6;
    localparam int CDB_ROB_WIDTH  = 5;

    // Request-slot assignment. Round-robin order follows slot order.
    localparam int CDB_REQ_ALU0 = 0;
    localparam int CDB_REQ_ALU1 = 1;
    localparam int CDB_REQ_AGU  = 2;
    localparam int CDB_REQ_LOAD = 3;

    // One CDB broadcast as seen by the ROB, reservation stations and the
    // physical register file wakeup logic.
    typedef struct packed {
        logic [CDB_DATA_WIDTH-1:0] data;
        logic [CDB_PREG_WIDTH-1:0] preg;
        logic [CDB_ROB_WIDTH-1:0]  rob;
    } cdb_packet_t;

endpackage : mips_core_pkg

// File: rtl/rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//
// Purpose:
//   Purely combinational round-robin picker. Scans the request vector starting
//   at position ptr, moving upwards and wrapping from N-1 back to 0, and
//   selects the first asserted request. N need not be a power of two: the
//   wrap is an explicit subtract of N, never a truncation of the index.
//
// Ports:
//   req          in   N    request vector
//   ptr          in   IW   highest-priority position this cycle (0..N-1)
//   grant        out  N    one-hot grant (all zero when no request)
//   grant_idx    out  IW   binary index of the granted position
//   grant_valid  out  1    some request was granted
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    // One extra bit so ptr + k (at most 2N-2) never overflows before the wrap.
    logic [IW:0] idx;

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so each path through the block drives every signal and
    // no latch can be inferred.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) begin
                idx = idx - (IW+1)'(N);
            end
            // First hit in scan order wins; later hits are ignored.
            if (!grant_valid && req[idx[IW-1:0]]) begin
                grant[idx[IW-1:0]] = 1'b1;
                grant_idx          = idx[IW-1:0];
                grant_valid        = 1'b1;
            end
        end
    end

endmodule : rr_picker

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Arbitrates the single common data bus between completing execution units.
//   One round-robin winner per cycle; the winner's payload is registered and
//   broadcast on cdb_* the following cycle as a single-cycle cdb_valid pulse.
//   A flush blocks all transfers for that cycle; a broadcast already on the
//   bus stays visible and is squashed by its consumers.
//
// Ports:
//   clk        in   1                   core clock
//   rst_n      in   1                   synchronous reset, active low
//   req_valid  in   N_REQ               unit i has a result pending
//   req_data   in   N_REQ x DATA_WIDTH  result value per unit
//   req_preg   in   N_REQ x PREG_WIDTH  destination physical register
//   req_rob    in   N_REQ x ROB_WIDTH   owning ROB entry
//   req_ready  out  N_REQ               one-hot grant; transfer on valid&ready
//   flush      in   1                   mispredict/exception squash
//   cdb_valid  out  1                   broadcast valid
//   cdb_data   out  DATA_WIDTH          broadcast value
//   cdb_preg   out  PREG_WIDTH          broadcast physical tag
//   cdb_rob    out  ROB_WIDTH           broadcast ROB index
// ---------------------------------------------------------------------------
module cdb_arbiter
    import mips_core_pkg::*;
#(
    parameter int N_REQ      = CDB_N_REQ,
    parameter int DATA_WIDTH = CDB_DATA_WIDTH,
    parameter int PREG_WIDTH = CDB_PREG_WIDTH,
    parameter int ROB_WIDTH  = CDB_ROB_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_REQ-1:0]                     req_valid,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_data,
    input  logic [N_REQ-1:0][PREG_WIDTH-1:0]     req_preg,
    input  logic [N_REQ-1:0][ROB_WIDTH-1:0]      req_rob,
    output logic [N_REQ-1:0]                     req_ready,
    input  logic                                 flush,
    output logic                                 cdb_valid,
    output logic [DATA_WIDTH-1:0]                cdb_data,
    output logic [PREG_WIDTH-1:0]                cdb_preg,
    output logic [ROB_WIDTH-1:0]                 cdb_rob
);

    localparam int IW = $clog2(N_REQ);

    // Payload layout matches cdb_packet_t but follows this instance's widths.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [PREG_WIDTH-1:0] preg;
        logic [ROB_WIDTH-1:0]  rob;
    } payload_t;

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    rr_ptr_next;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    grant_idx;
    logic             grant_valid;
    logic             xfer;
    payload_t         sel_pkt;
    payload_t         cdb_q;
    logic             cdb_valid_q;

    // -----------------------------------------------------------------------
    // Grant selection
    // -----------------------------------------------------------------------
    rr_picker #(
        .N (N_REQ)
    ) u_picker (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Grants are suppressed during reset and flush so no requester sees a
    // handshake that the output stage is going to drop.
    assign xfer      = grant_valid && rst_n && !flush;
    assign req_ready = xfer ? grant : '0;

    // Winner moves to lowest priority: the scan restarts just past it, with
    // an explicit wrap so non-power-of-two N_REQ never lands on a dead slot.
    assign rr_ptr_next = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + IW'(1);

    // -----------------------------------------------------------------------
    // Payload mux: AND-OR over the one-hot grant
    // -----------------------------------------------------------------------
    always_comb begin
        sel_pkt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_pkt.data = sel_pkt.data | req_data[i];
                sel_pkt.preg = sel_pkt.preg | req_preg[i];
                sel_pkt.rob  = sel_pkt.rob  | req_rob[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Round-robin pointer and broadcast register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking '<=' so every register samples
    // pre-edge values and simulation order between processes cannot matter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_q       <= '0;
        end else begin
            // Valid is a one-cycle pulse per grant; with no transfer the
            // payload holds its last value so the bus does not toggle.
            cdb_valid_q <= xfer;
            if (xfer) begin
                rr_ptr <= rr_ptr_next;
                cdb_q  <= sel_pkt;
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_data  = cdb_q.data;
    assign cdb_preg  = cdb_q.preg;
    assign cdb_rob   = cdb_q.rob;

    // -----------------------------------------------------------------------
    // Simulation checks on the handshake
    // -----------------------------------------------------------------------
    a_ready_onehot0 : assert property (@(posedge clk) $onehot0(req_ready));
    a_ready_has_valid : assert property (@(posedge clk) (req_ready & ~req_valid) == '0);

endmodule : cdb_arbiter

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Drives a 4-requester cdb_arbiter with directed vectors and checks it every
// cycle against a behavioural model (round-robin scan with modulo arithmetic
// and a one-deep broadcast register). Directed literal expectations pin the
// model. A second 3-requester instance exercises the non-power-of-two wrap.
// Inputs change 1 time unit after posedge; everything is sampled at negedge.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    logic clk;
    logic rst_n;
    logic flush;

    // 4-requester instance
    logic [3:0]        req_valid;
    logic [3:0][31:0]  req_data;
    logic [3:0][5:0]   req_preg;
    logic [3:0][4:0]   req_rob;
    logic [3:0]        req_ready;
    logic              cdb_valid;
    logic [31:0]       cdb_data;
    logic [5:0]        cdb_preg;
    logic [4:0]        cdb_rob;

    // 3-requester instance
    logic [2:0]        v3;
    logic [2:0][31:0]  d3;
    logic [2:0][5:0]   p3;
    logic [2:0][4:0]   r3;
    logic [2:0]        ready3;
    logic              cdb3_valid;
    logic [31:0]       cdb3_data;
    logic [5:0]        cdb3_preg;
    logic [4:0]        cdb3_rob;

    int n_checks = 0;
    int n_pass   = 0;

    cdb_arbiter #(.N_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_preg  (req_preg),
        .req_rob   (req_rob),
        .req_ready (req_ready),
        .flush     (flush),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_preg  (cdb_preg),
        .cdb_rob   (cdb_rob)
    );

    cdb_arbiter #(.N_REQ(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (v3),
        .req_data  (d3),
        .req_preg  (p3),
        .req_rob   (r3),
        .req_ready (ready3),
        .flush     (flush),
        .cdb_valid (cdb3_valid),
        .cdb_data  (cdb3_data),
        .cdb_preg  (cdb3_preg),
        .cdb_rob   (cdb3_rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Behavioural model of the 4-requester instance
    // -----------------------------------------------------------------------
    int          m_ptr     = 0;
    bit          m_valid   = 1'b0;
    logic [31:0] m_data    = '0;
    logic [5:0]  m_preg    = '0;
    logic [4:0]  m_rob     = '0;
    bit          m_started = 1'b0;

    // Index of the first valid requester scanning from ptr, or -1 if none.
    function automatic int model_pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (ptr + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        m_started = 1'b1;
        if (!rst_n) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_preg  = '0;
            m_rob   = '0;
        end else begin
            g = flush ? -1 : model_pick(req_valid, m_ptr);
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = req_data[g];
                m_preg  = req_preg[g];
                m_rob   = req_rob[g];
                m_ptr   = (g + 1) % 4;
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    // Every-cycle comparison once the first edge has applied reset.
    always @(negedge clk) begin
        int          g;
        logic [3:0]  exp_ready;
        if (m_started) begin
            g = model_pick(req_valid, m_ptr);
            exp_ready = (!rst_n || flush || g < 0) ? 4'b0000 : 4'(1 << g);
            check("model req_ready", 64'(req_ready), 64'(exp_ready));
            check("model cdb_valid", 64'(cdb_valid), 64'(m_valid));
            check("model cdb_data",  64'(cdb_data),  64'(m_data));
            check("model cdb_preg",  64'(cdb_preg),  64'(m_preg));
            check("model cdb_rob",   64'(cdb_rob),   64'(m_rob));
        end
    end

    // -----------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_data[i] = 32'h1111_1111 * (i + 1);
            req_preg[i] = 6'(i + 8);
            req_rob[i]  = 5'(i);
        end
        v3 = '0;
        for (int i = 0; i < 3; i++) begin
            d3[i] = 32'hA000_0000 + 32'(i);
            p3[i] = 6'(i + 20);
            r3[i] = 5'(i + 16);
        end

        // Reset held 3 cycles with every requester valid.
        for (int c = 0; c < 3; c++) begin
            tick();
            sample();
            check("reset req_ready", 64'(req_ready), 64'h0);
            check("reset cdb_valid", 64'(cdb_valid), 64'h0);
            check("reset cdb_data",  64'(cdb_data),  64'h0);
        end

        // Single request from unit 2.
        tick();
        rst_n       = 1'b1;
        req_valid   = 4'b0100;
        req_data[2] = 32'hDEAD_BEEF;
        req_preg[2] = 6'd7;
        req_rob[2]  = 5'd3;
        sample();
        check("single req_ready", 64'(req_ready), 64'b0100);
        tick();
        req_valid = 4'b0000;
        sample();
        check("single cdb_valid", 64'(cdb_valid), 64'h1);
        check("single cdb_data",  64'(cdb_data),  64'hDEAD_BEEF);
        check("single cdb_preg",  64'(cdb_preg),  64'd7);
        check("single cdb_rob",   64'(cdb_rob),   64'd3);
        tick();
        sample();
        check("single pulse end", 64'(cdb_valid), 64'h0);
        check("single data hold", 64'(cdb_data),  64'hDEAD_BEEF);

        // Fairness from a fresh pointer: all four held for 8 cycles.
        tick();
        rst_n = 1'b0;
        req_preg[2] = 6'd10;
        req_rob[2]  = 5'd2;
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            sample();
            check("fair grant", 64'(req_ready), 64'(1 << (k % 4)));
            if (k > 0) begin
                check("fair cdb_rob", 64'(cdb_rob), 64'((k - 1) % 4));
            end
            tick();
        end
        req_valid = 4'b0000;
        sample();
        check("fair last rob", 64'(cdb_rob), 64'd3);

        // Flush blocks a transfer; pointer (0) holds so unit 1 wins after.
        req_valid = 4'b0010;
        flush     = 1'b1;
        sample();
        check("flush req_ready", 64'(req_ready), 64'h0);
        tick();
        flush = 1'b0;
        sample();
        check("flush cdb_valid", 64'(cdb_valid), 64'h0);
        check("post-flush grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b1000;
        sample();
        check("post-flush bcast", 64'(cdb_rob), 64'd1);
        check("grant 3", 64'(req_ready), 64'b1000);

        // Flush right after a grant: that broadcast is still visible.
        tick();
        req_valid = 4'b0001;
        flush     = 1'b1;
        sample();
        check("flush keeps bcast valid", 64'(cdb_valid), 64'h1);
        check("flush keeps bcast rob",   64'(cdb_rob),   64'd3);
        tick();
        flush = 1'b0;
        req_valid = 4'b0010;
        sample();
        check("flush-after cdb_valid", 64'(cdb_valid), 64'h0);
        check("grant 1 before reset",  64'(req_ready), 64'b0010);

        // Reset (with flush) mid-broadcast after pointer moved to 2.
        tick();
        rst_n     = 1'b0;
        flush     = 1'b1;
        req_valid = 4'b1001;
        sample();
        check("reset-mid ready", 64'(req_ready), 64'h0);
        check("reset-mid bcast still", 64'(cdb_valid), 64'h1);
        tick();
        rst_n = 1'b1;
        flush = 1'b0;
        sample();
        check("reset-mid cdb_valid", 64'(cdb_valid), 64'h0);
        check("reset-mid grant 0", 64'(req_ready), 64'b0001);
        tick();
        req_valid = 4'b0000;

        // N_REQ = 3 wrap: move pointer to 2, then 011 -> grant 0, then 1.
        v3 = 3'b010;
        sample();
        check("n3 grant 1", 64'(ready3), 64'b010);
        tick();
        v3 = 3'b011;
        sample();
        check("n3 wrap grant 0", 64'(ready3), 64'b001);
        tick();
        sample();
        check("n3 next grant 1", 64'(ready3), 64'b010);
        check("n3 cdb_rob", 64'(cdb3_rob), 64'd16);
        tick();
        v3 = 3'b000;
        sample();
        check("n3 cdb_rob 1", 64'(cdb3_rob), 64'd17);
        check("n3 cdb_data", 64'(cdb3_data), 64'hA000_0001);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cdb_arbiter
